// File: rtl/lfsr_checker_pkg.sv
// lfsr_checker_pkg: definitions shared by the 14-bit sequence generator and
// its receive-side checker (register width, tap positions, state encoding).
package lfsr_checker_pkg;

   localparam int unsigned LFSR_W = 14;

   localparam int unsigned TAP_A = 13;
   localparam int unsigned TAP_B = 4;
   localparam int unsigned TAP_C = 2;
   localparam int unsigned TAP_D = 0;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } lfsr_state_t;

   // Feedback bit produced from a register value (shift-left, enters at bit 0).
   function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] v);
      return v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
   endfunction

endpackage

// File: rtl/lfsr_chk_predict.sv
// lfsr_chk_predict: combinational next-bit predictor for the 14-bit sequence.
module lfsr_chk_predict
   import lfsr_checker_pkg::*;
(
   input  logic [LFSR_W-1:0] sr,
   output logic              exp_bit_c
);

   // Next sequence bit implied by the current register contents.
   always_comb begin
      exp_bit_c = lfsr_feedback(sr);
   end

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising serial checker for the 14-bit sequence.
// Loads its register from the received bits, predicts each following bit and
// reports lock, per-bit error pulses and saturating error/bit counters.
// Optional feature: define LFSR_CHK_AUTO_RESYNC_EN to drop lock after
// LOSS_THRESH consecutive mispredictions and refill from the stream.
module lfsr_checker
   import lfsr_checker_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned LOCK_THRESH = 14,
   parameter int unsigned LOSS_THRESH = 4
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count,
   output logic [1:0]       state
);

   localparam int unsigned FILL_W = 4;
   localparam int unsigned RUN_W  = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Threshold ranges the counters are sized for.
   if (LOCK_THRESH == 0 || LOCK_THRESH > 255) begin : g_bad_lock_thresh
      $error("lfsr_checker: LOCK_THRESH must be 1..255");
   end
   if (LOSS_THRESH == 0 || LOSS_THRESH > 255) begin : g_bad_loss_thresh
      $error("lfsr_checker: LOSS_THRESH must be 1..255");
   end

   lfsr_state_t       state_q;
   logic [LFSR_W-1:0] sr;
   logic [LFSR_W-1:0] sr_shift;
   logic [FILL_W-1:0] fill_cnt;
   logic [RUN_W-1:0]  run_cnt;
   logic              exp_bit;
   logic              mismatch;
   logic              sr_zero;
`ifdef LFSR_CHK_AUTO_RESYNC_EN
   localparam int unsigned LOSS_W = 8;
   logic [LOSS_W-1:0] miss_cnt;
`endif

   lfsr_chk_predict u_predict (
      .sr        (sr),
      .exp_bit_c (exp_bit)
   );

   assign sr_shift = {sr[LFSR_W-2:0], in_bit};
   assign mismatch = in_valid & (in_bit != exp_bit);
   assign sr_zero  = (sr_shift == '0);
   assign state    = state_q;

   // Sequence register, fill/run counters and the FILL -> VERIFY -> LOCKED walk.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_FILL;
         sr       <= '0;
         fill_cnt <= '0;
         run_cnt  <= '0;
         locked   <= 1'b0;
`ifdef LFSR_CHK_AUTO_RESYNC_EN
         miss_cnt <= '0;
`endif
      end else if (in_valid) begin
         sr <= sr_shift;
         case (state_q)
            ST_FILL: begin
               if (fill_cnt == FILL_W'(LFSR_W - 1)) begin
                  state_q  <= ST_VERIFY;
                  fill_cnt <= '0;
                  run_cnt  <= '0;
               end else begin
                  fill_cnt <= fill_cnt + FILL_W'(1);
               end
            end
            ST_VERIFY: begin
               if (sr_zero) begin
                  state_q  <= ST_FILL;
                  fill_cnt <= '0;
               end else if (mismatch) begin
                  run_cnt <= '0;
               end else if (run_cnt == RUN_W'(LOCK_THRESH - 1)) begin
                  state_q <= ST_LOCKED;
                  locked  <= 1'b1;
                  run_cnt <= '0;
`ifdef LFSR_CHK_AUTO_RESYNC_EN
                  miss_cnt <= '0;
`endif
               end else begin
                  run_cnt <= run_cnt + RUN_W'(1);
               end
            end
            ST_LOCKED: begin
               if (sr_zero) begin
                  state_q  <= ST_FILL;
                  fill_cnt <= '0;
                  locked   <= 1'b0;
               end
`ifdef LFSR_CHK_AUTO_RESYNC_EN
               else if (mismatch) begin
                  if (miss_cnt == LOSS_W'(LOSS_THRESH - 1)) begin
                     state_q  <= ST_FILL;
                     fill_cnt <= '0;
                     locked   <= 1'b0;
                     miss_cnt <= '0;
                  end else begin
                     miss_cnt <= miss_cnt + LOSS_W'(1);
                  end
               end else begin
                  miss_cnt <= '0;
               end
`endif
            end
            default: begin
               state_q  <= ST_FILL;
               fill_cnt <= '0;
               locked   <= 1'b0;
            end
         endcase
      end
   end

   // Error pulse and saturating counters for bits checked while locked.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_pulse <= 1'b0;
         err_count <= '0;
         bit_count <= '0;
      end else begin
         err_pulse <= mismatch && (state_q == ST_LOCKED);
         if (clear_cnt) begin
            err_count <= '0;
            bit_count <= '0;
         end else if (in_valid && (state_q == ST_LOCKED)) begin
            if (bit_count != CNT_MAX) begin
               bit_count <= bit_count + CNT_W'(1);
            end
            if (mismatch && (err_count != CNT_MAX)) begin
               err_count <= err_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scenario tasks against a history-based reference model.
module tb_lfsr_checker;

   localparam int unsigned CNT_W       = 8;
   localparam int unsigned LOCK_THRESH = 14;
   localparam int unsigned LOSS_THRESH = 4;
   localparam int          CMAX        = (1 << CNT_W) - 1;

   logic             clock;
   logic             reset;
   logic             in_valid;
   logic             in_bit;
   logic             clear_cnt;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;
   logic [1:0]       state;

   int errors = 0;
   int checks = 0;

   // reference model: history of received valid bits plus mode counters
   bit  hist[$];
   int  m_mode, m_fill, m_run, m_miss, m_errc, m_bitc;
   bit  m_pulse;
   logic [13:0] g;

   lfsr_checker #(
      .CNT_W       (CNT_W),
      .LOCK_THRESH (LOCK_THRESH),
      .LOSS_THRESH (LOSS_THRESH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .clear_cnt (clear_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .bit_count (bit_count),
      .state     (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // k-th most recent received bit (k=1 newest); absent history reads as 0
   function automatic bit hbit(input int k);
      if (k <= hist.size()) return hist[hist.size() - k];
      return 1'b0;
   endfunction

   function automatic bit model_exp();
      return hbit(14) ^ hbit(5) ^ hbit(3) ^ hbit(1);
   endfunction

   task automatic model_reset();
      hist.delete();
      m_mode = 0; m_fill = 0; m_run = 0; m_miss = 0;
      m_errc = 0; m_bitc = 0; m_pulse = 1'b0;
   endtask

   task automatic model_step(input bit v, input bit b, input bit clr);
      bit mis;
      bit zero;
      m_pulse = 1'b0;
      if (v) begin
         mis = (b != model_exp());
         hist.push_back(b);
         if (hist.size() > 14) void'(hist.pop_front());
         zero = 1'b1;
         foreach (hist[i]) if (hist[i]) zero = 1'b0;
         if (m_mode == 2) begin
            if (m_bitc < CMAX) m_bitc++;
            if (mis) begin
               m_pulse = 1'b1;
               if (m_errc < CMAX) m_errc++;
            end
         end
         case (m_mode)
            0: begin
               m_fill++;
               if (m_fill == 14) begin m_mode = 1; m_fill = 0; m_run = 0; end
            end
            1: begin
               if (zero) begin m_mode = 0; m_fill = 0; end
               else if (mis) m_run = 0;
               else begin
                  m_run++;
                  if (m_run == int'(LOCK_THRESH)) begin m_mode = 2; m_miss = 0; end
               end
            end
            default: begin
               if (zero) begin m_mode = 0; m_fill = 0; end
`ifdef LFSR_CHK_AUTO_RESYNC_EN
               else if (mis) begin
                  m_miss++;
                  if (m_miss == int'(LOSS_THRESH)) begin m_mode = 0; m_fill = 0; end
               end else m_miss = 0;
`endif
            end
         endcase
      end
      if (clr) begin m_errc = 0; m_bitc = 0; end
   endtask

   task automatic gen_next(output bit nb);
      nb = g[13] ^ g[4] ^ g[2] ^ g[0];
      g  = {g[12:0], nb};
   endtask

   task automatic drive(input bit v, input bit b, input bit clr);
      in_valid  = v;
      in_bit    = b;
      clear_cnt = clr;
      @(posedge clock);
      #1;
      model_step(v, b, clr);
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic lock_clean();
      bit b;
      g = 14'h0001;
      repeat (28) begin gen_next(b); drive(1'b1, b, 1'b0); end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; clear_cnt = 1'b0;
      repeat (3) begin in_bit = 1'($urandom_range(0, 1)); @(posedge clock); end
      #1;
      checks++;
      if (state !== 2'd0 || locked !== 1'b0 || err_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: state=%0d locked=%b err_pulse=%b, want 0/0/0", state, locked, err_pulse);
      end
      checks++;
      if (err_count !== '0 || bit_count !== '0) begin
         errors++;
         $display("FAIL reset_counts: err_count=%0d bit_count=%0d, want 0/0", err_count, bit_count);
      end
      reset = 1'b0; in_valid = 1'b0;
      model_reset();
   endtask

   task automatic test_clean_lock();
      bit b;
      do_reset();
      g = 14'h0001;
      for (int i = 1; i <= 28; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
         if (i == 14) begin
            checks++;
            if (state !== 2'd1) begin
               errors++;
               $display("FAIL fill_to_verify: state=%0d after bit 14, want 1", state);
            end
         end
         if (i == 27) begin
            checks++;
            if (locked !== 1'b0) begin
               errors++;
               $display("FAIL early_lock: locked=%b after bit 27, want 0", locked);
            end
         end
      end
      checks++;
      if (locked !== 1'b1 || state !== 2'd2) begin
         errors++;
         $display("FAIL lock_point: locked=%b state=%0d after bit 28, want 1/2", locked, state);
      end
      for (int i = 0; i < 100; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
         checks++;
         if (err_pulse !== 1'b0 || state !== 2'd2) begin
            errors++;
            $display("FAIL clean_run: bit %0d err_pulse=%b state=%0d, want 0/2", i, err_pulse, state);
         end
      end
      checks++;
      if (bit_count !== CNT_W'(100) || err_count !== '0) begin
         errors++;
         $display("FAIL clean_counts: bit_count=%0d err_count=%0d, want 100/0", bit_count, err_count);
      end
   endtask

   task automatic test_bit_flip();
      bit b;
      int pos[$];
      int exp_pos[5] = '{0, 1, 3, 5, 14};
      int e0;
      e0 = m_errc;
      for (int k = 0; k < 30; k++) begin
         gen_next(b);
         if (k == 0) b = ~b;
         drive(1'b1, b, 1'b0);
         checks++;
         if (err_pulse !== m_pulse) begin
            errors++;
            $display("FAIL flip_pulse: offset %0d err_pulse=%b, want %b", k, err_pulse, m_pulse);
         end
         if (err_pulse === 1'b1) pos.push_back(k);
      end
      checks++;
      if (pos.size() != 5) begin
         errors++;
         $display("FAIL flip_count: %0d pulses, want 5", pos.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (pos[i] != exp_pos[i]) begin
               errors++;
               $display("FAIL flip_offset: pulse %0d at %0d, want %0d", i, pos[i], exp_pos[i]);
            end
         end
      end
      checks++;
      if (int'(err_count) != e0 + 5 || locked !== 1'b1) begin
         errors++;
         $display("FAIL flip_errcount: err_count=%0d locked=%b, want %0d/1", err_count, locked, e0 + 5);
      end
   endtask

   task automatic test_clear_mismatch();
      bit b;
      gen_next(b);
      drive(1'b1, ~b, 1'b1);
      checks++;
      if (err_pulse !== 1'b1 || err_count !== '0 || bit_count !== '0) begin
         errors++;
         $display("FAIL clear_vs_err: err_pulse=%b err_count=%0d bit_count=%0d, want 1/0/0", err_pulse, err_count, bit_count);
      end
      repeat (20) begin gen_next(b); drive(1'b1, b, 1'b0); end
      checks++;
      if (err_count !== CNT_W'(4) || bit_count !== CNT_W'(20) || locked !== 1'b1) begin
         errors++;
         $display("FAIL clear_after: err_count=%0d bit_count=%0d locked=%b, want 4/20/1", err_count, bit_count, locked);
      end
   endtask

   task automatic test_valid_toggle();
      bit b;
      bit v;
      int nvalid = 0;
      do_reset();
      g = 14'h0001;
      for (int c = 0; c < 200 && nvalid < 60; c++) begin
         v = (c % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (v) begin gen_next(b); nvalid++; end
         else b = 1'($urandom_range(0, 1));
         drive(v, b, 1'b0);
         checks++;
         if (locked !== (nvalid >= 28) || int'(bit_count) != m_bitc ||
             int'(state) != m_mode || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL valid_toggle: cycle %0d v=%b nvalid=%0d locked=%b state=%0d bit_count=%0d err_pulse=%b, want locked=%b state=%0d bit_count=%0d pulse=0",
                     c, v, nvalid, locked, state, bit_count, err_pulse, (nvalid >= 28), m_mode, m_bitc);
         end
      end
      checks++;
      if (bit_count !== CNT_W'(nvalid - 28)) begin
         errors++;
         $display("FAIL toggle_bitcount: bit_count=%0d, want %0d", bit_count, nvalid - 28);
      end
   endtask

   task automatic test_all_zero();
      int es;
      do_reset();
      for (int n = 1; n <= 40; n++) begin
         drive(1'b1, 1'b0, 1'b0);
         es = (n % 15 == 14) ? 1 : 0;
         checks++;
         if (int'(state) != es || locked !== 1'b0) begin
            errors++;
            $display("FAIL all_zero: bit %0d state=%0d locked=%b, want %0d/0", n, state, locked, es);
         end
      end
   endtask

   task automatic test_midstream_reset();
      bit b;
      do_reset();
      lock_clean();
      repeat (5) begin gen_next(b); drive(1'b1, b, 1'b0); end
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (state !== 2'd0 || locked !== 1'b0 || bit_count !== '0 || err_count !== '0) begin
         errors++;
         $display("FAIL midstream_reset: state=%0d locked=%b bit_count=%0d err_count=%0d, want 0/0/0/0", state, locked, bit_count, err_count);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_saturation();
      bit b;
      do_reset();
      lock_clean();
      repeat (300) begin gen_next(b); drive(1'b1, b, 1'b0); end
      checks++;
      if (bit_count !== CNT_W'(CMAX) || err_count !== '0) begin
         errors++;
         $display("FAIL saturation: bit_count=%0d err_count=%0d, want %0d/0", bit_count, err_count, CMAX);
      end
   endtask

`ifdef LFSR_CHK_AUTO_RESYNC_EN
   task automatic test_resync();
      bit b;
      do_reset();
      lock_clean();
      repeat (10) begin gen_next(b); drive(1'b1, b, 1'b0); end
      for (int k = 1; k <= 4; k++) begin
         gen_next(b);
         drive(1'b1, ~model_exp(), 1'b0);
         checks++;
         if ((k < 4 && (state !== 2'd2 || locked !== 1'b1)) ||
             (k == 4 && (state !== 2'd0 || locked !== 1'b0)) || err_count !== CNT_W'(k)) begin
            errors++;
            $display("FAIL resync: bad bit %0d state=%0d locked=%b err_count=%0d", k, state, locked, err_count);
         end
      end
      for (int i = 1; i <= 28; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
         checks++;
         if (locked !== (i == 28) || err_count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL relock: bit %0d locked=%b err_count=%0d, want %b/4", i, locked, err_count, (i == 28));
         end
      end
   endtask
`endif

   task automatic test_random();
      bit b;
      bit v;
      bit clr;
      do_reset();
      g = 14'($urandom_range(1, 16383));
      for (int c = 0; c < 1500; c++) begin
         v   = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 99) == 0);
         if (c < 40) b = 1'($urandom_range(0, 1));
         else if (c >= 700 && c < 720) b = 1'b0;
         else begin
            gen_next(b);
            if ($urandom_range(0, 39) == 0) b = ~b;
         end
         drive(v, b, clr);
         checks++;
         if (int'(state) != m_mode || locked !== (m_mode == 2) || err_pulse !== m_pulse ||
             int'(err_count) != m_errc || int'(bit_count) != m_bitc) begin
            errors++;
            $display("FAIL random: cycle %0d state=%0d locked=%b pulse=%b err=%0d bits=%0d, want %0d/%b/%b/%0d/%0d",
                     c, state, locked, err_pulse, err_count, bit_count, m_mode, (m_mode == 2), m_pulse, m_errc, m_bitc);
         end
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
      model_reset();
      test_reset();
      test_clean_lock();
      test_bit_flip();
      test_clear_mismatch();
      test_valid_toggle();
      test_all_zero();
      test_midstream_reset();
      test_saturation();
`ifdef LFSR_CHK_AUTO_RESYNC_EN
      test_resync();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
